// File: rtl/addr_req_stage.sv
// Two-entry elastic request buffer feeding the address-range qualifier; illegal kinds are dropped with err_pulse.
// Optional request/stall counters are enabled by defining ADDR_REQ_STAGE_STATS_EN.
module addr_req_stage #(
  parameter int unsigned AW    = 25,
  parameter int unsigned DEPTH = 2
) (
  input  logic          go,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [1:0]    req_kind,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] d,
  output logic          b,
  output logic          c,
  output logic          e,
`ifdef ADDR_REQ_STAGE_STATS_EN
  output logic [15:0]   stat_acc,
  output logic [15:0]   stat_stall,
`endif
  output logic          err_pulse
);

  if (DEPTH != 2) begin : g_depth_check
    $error("addr_req_stage: DEPTH must be 2");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [1:0] KIND_READ    = 2'b00;
  localparam logic [1:0] KIND_WRITE   = 2'b01;
  localparam logic [1:0] KIND_SNOOP   = 2'b10;
  localparam logic [1:0] KIND_ILLEGAL = 2'b11;

  state_t        state_q, state_d;
  logic          req_ready_q, req_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] head_addr_q, head_addr_d;
  logic [1:0]    head_kind_q, head_kind_d;
  logic [AW-1:0] tail_addr_q, tail_addr_d;
  logic [1:0]    tail_kind_q, tail_kind_d;
  logic          b_q, b_d;
  logic          c_q, c_d;
  logic          e_q, e_d;
  logic          err_q, err_d;

  logic push, pop, legal_push, illegal_push;

  always_comb begin
    push         = req_valid & req_ready_q;
    pop          = out_valid_q & out_ready;
    illegal_push = push & (req_kind == KIND_ILLEGAL);
    legal_push   = push & (req_kind != KIND_ILLEGAL);

    state_d     = state_q;
    head_addr_d = head_addr_q;
    head_kind_d = head_kind_q;
    tail_addr_d = tail_addr_q;
    tail_kind_d = tail_kind_q;

    case (state_q)
      EMPTY: begin
        if (legal_push) begin
          head_addr_d = req_addr;
          head_kind_d = req_kind;
          state_d     = HALF;
        end
      end
      HALF: begin
        // With a concurrent pop the incoming request replaces the head directly,
        // which keeps one-per-cycle streaming without ever touching the tail.
        if (legal_push && pop) begin
          head_addr_d = req_addr;
          head_kind_d = req_kind;
        end else if (legal_push) begin
          tail_addr_d = req_addr;
          tail_kind_d = req_kind;
          state_d     = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_addr_d = tail_addr_q;
          head_kind_d = tail_kind_q;
          state_d     = HALF;
        end
      end
      default: state_d = EMPTY;
    endcase

    out_valid_d = (state_d != EMPTY);
    req_ready_d = (state_d != FULL);
    b_d         = out_valid_d & (head_kind_d == KIND_READ);
    c_d         = out_valid_d & (head_kind_d == KIND_WRITE);
    e_d         = out_valid_d & (head_kind_d == KIND_SNOOP);
    err_d       = illegal_push;
  end

  always_ff @(posedge go or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      req_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      head_addr_q <= '0;
      head_kind_q <= '0;
      tail_addr_q <= '0;
      tail_kind_q <= '0;
      b_q         <= 1'b0;
      c_q         <= 1'b0;
      e_q         <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      out_valid_q <= out_valid_d;
      head_addr_q <= head_addr_d;
      head_kind_q <= head_kind_d;
      tail_addr_q <= tail_addr_d;
      tail_kind_q <= tail_kind_d;
      b_q         <= b_d;
      c_q         <= c_d;
      e_q         <= e_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign out_valid = out_valid_q;
  assign d         = head_addr_q;
  assign b         = b_q;
  assign c         = c_q;
  assign e         = e_q;
  assign err_pulse = err_q;

`ifdef ADDR_REQ_STAGE_STATS_EN
  logic [15:0] acc_q, acc_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    acc_d   = acc_q;
    stall_d = stall_q;
    if (legal_push && (acc_q != '1)) acc_d = acc_q + 16'd1;
    if (req_valid && !req_ready_q && (stall_q != '1)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge go or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      stall_q <= '0;
    end else begin
      acc_q   <= acc_d;
      stall_q <= stall_d;
    end
  end

  assign stat_acc   = acc_q;
  assign stat_stall = stall_q;
`endif

endmodule
